// File: rtl/id_ex_stage_pkg.sv
// rtl/id_ex_stage_pkg.sv - shared opcodes, ALUOp encodings and control bundle for the ID/EX stage
package id_ex_stage_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_SH    = 6'b101001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_LH    = 6'b100001;
  localparam logic [5:0] OP_LW    = 6'b100011;

  localparam logic [1:0] ALUOP_MEM   = 2'b00;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_IMM   = 2'b11;

  // Decoder control bits travelling with the instruction; all-zero is a NOP.
  typedef struct packed {
    logic       reg_dst;
    logic       alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic [1:0] alu_op;
  } ctrl_t;

  // Instructions that actually read rt as a source (R-type, branches, stores).
  function automatic logic uses_rt(input logic [5:0] op);
    logic r;
    r = 1'b0;
    case (op)
      OP_RTYPE, OP_BEQ, OP_BNE, OP_SB, OP_SH, OP_SW: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/id_ex_stage_hazard_detect.sv
// rtl/id_ex_stage_hazard_detect.sv - combinational load-use hazard detection and stall enables
module hazard_detect
  import id_ex_stage_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic [5:0]       id_op_code,
  input  logic             flush,
  input  logic             freeze,
  output logic             hazard,
  output logic             pc_write,
  output logic             if_id_write
);

  logic rs_match;
  logic rt_match;

  // Register $zero never carries a real dependency, so a load into it never stalls.
  assign rs_match    = (ex_rt == id_rs);
  assign rt_match    = uses_rt(id_op_code) & (ex_rt == id_rt);
  assign hazard      = ex_mem_read & (ex_rt != '0) & (rs_match | rt_match);

  // A flushed instruction is dead, so its hazard must not stall the front end.
  assign pc_write    = ~(hazard & ~flush) & ~freeze;
  assign if_id_write = ~(hazard & ~flush) & ~freeze;

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with load-use bubble insertion and bubble counter
module id_ex_stage
  import id_ex_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              freeze,
  input  logic              flush,
  input  logic [5:0]        id_op_code,
  input  logic              id_RegDst,
  input  logic              id_ALUSrc,
  input  logic              id_MemToReg,
  input  logic              id_RegWrite,
  input  logic              id_MemRead,
  input  logic              id_MemWrite,
  input  logic              id_Branch,
  input  logic [1:0]        id_ALUOp,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [DATA_W-1:0] id_rs_data,
  input  logic [DATA_W-1:0] id_rt_data,
  input  logic [DATA_W-1:0] id_imm,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic [REG_W-1:0]  id_rd,
  input  logic [5:0]        id_funct,
  output logic              ex_RegDst,
  output logic              ex_ALUSrc,
  output logic              ex_MemToReg,
  output logic              ex_RegWrite,
  output logic              ex_MemRead,
  output logic              ex_MemWrite,
  output logic              ex_Branch,
  output logic [1:0]        ex_ALUOp,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_imm,
  output logic [REG_W-1:0]  ex_rs,
  output logic [REG_W-1:0]  ex_rt,
  output logic [REG_W-1:0]  ex_rd,
  output logic [5:0]        ex_funct,
  output logic              pc_write,
  output logic              if_id_write,
  output logic [CNT_W-1:0]  bubble_count
);

  ctrl_t id_ctrl;
  ctrl_t ex_ctrl;
  logic  hazard;

  assign id_ctrl = {id_RegDst, id_ALUSrc, id_MemToReg, id_RegWrite,
                    id_MemRead, id_MemWrite, id_Branch, id_ALUOp};

  assign ex_RegDst   = ex_ctrl.reg_dst;
  assign ex_ALUSrc   = ex_ctrl.alu_src;
  assign ex_MemToReg = ex_ctrl.mem_to_reg;
  assign ex_RegWrite = ex_ctrl.reg_write;
  assign ex_MemRead  = ex_ctrl.mem_read;
  assign ex_MemWrite = ex_ctrl.mem_write;
  assign ex_Branch   = ex_ctrl.branch;
  assign ex_ALUOp    = ex_ctrl.alu_op;

  hazard_detect #(
    .REG_W (REG_W)
  ) u_hazard_detect (
    .ex_mem_read (ex_ctrl.mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_op_code  (id_op_code),
    .flush       (flush),
    .freeze      (freeze),
    .hazard      (hazard),
    .pc_write    (pc_write),
    .if_id_write (if_id_write)
  );

  // Pipeline register: hold on freeze, zero the controls on flush or hazard, else load.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ex_ctrl     <= '0;
      ex_pc_plus4 <= '0;
      ex_rs_data  <= '0;
      ex_rt_data  <= '0;
      ex_imm      <= '0;
      ex_rs       <= '0;
      ex_rt       <= '0;
      ex_rd       <= '0;
      ex_funct    <= '0;
    end else if (!freeze) begin
      ex_ctrl     <= (flush || hazard) ? ctrl_t'('0) : id_ctrl;
      ex_pc_plus4 <= id_pc_plus4;
      ex_rs_data  <= id_rs_data;
      ex_rt_data  <= id_rt_data;
      ex_imm      <= id_imm;
      ex_rs       <= id_rs;
      ex_rt       <= id_rt;
      ex_rd       <= id_rd;
      ex_funct    <= id_funct;
    end
  end

  // Saturating count of load-use bubbles; flush bubbles are not stalls and are not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bubble_count <= '0;
    end else if (!freeze && !flush && hazard && (bubble_count != {CNT_W{1'b1}})) begin
      bubble_count <= bubble_count + CNT_W'(1);
    end
  end

endmodule
